// File: rtl/axi_llc_read_unit.sv
`default_nettype none
// ============================================================================
//  Module   : axi_llc_read_unit
//  Brief    : LLC read-hit unit. Walks a hit read descriptor beat by beat,
//             issues one data-way read per beat, buffers returned words and
//             drives the AXI R channel (id/resp/last). The line is unlocked
//             in the same cycle its final way request is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_llc_read_unit #(
    parameter int ID_WIDTH         = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int LEN_WIDTH        = 8,
    parameter int DATA_WIDTH       = 64,
    parameter int BYTE_OFFSET_LEN  = 3,
    parameter int BLOCK_OFFSET_LEN = 3,
    parameter int INDEX_WIDTH      = 8,
    parameter int SET_ASSO         = 4,
    parameter int RBUF_DEPTH       = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        test_i,
    // read descriptor
    input  logic [ID_WIDTH-1:0]         desc_a_x_id_i,
    input  logic [ADDR_WIDTH-1:0]       desc_a_x_addr_i,
    input  logic [LEN_WIDTH-1:0]        desc_a_x_len_i,
    input  logic [2:0]                  desc_a_x_size_i,
    input  logic [1:0]                  desc_a_x_burst_i,
    input  logic [1:0]                  desc_x_resp_i,
    input  logic                        desc_x_last_i,
    input  logic [SET_ASSO-1:0]         desc_way_ind_i,
    input  logic [INDEX_WIDTH-1:0]      desc_index_partition_i,
    input  logic                        desc_valid_i,
    output logic                        desc_ready_o,
    // data-way read request
    output logic [1:0]                  way_inp_cache_unit_o,
    output logic [SET_ASSO-1:0]         way_inp_way_ind_o,
    output logic [INDEX_WIDTH-1:0]      way_inp_line_addr_o,
    output logic [BLOCK_OFFSET_LEN-1:0] way_inp_blk_offset_o,
    output logic                        way_inp_we_o,
    output logic [DATA_WIDTH-1:0]       way_inp_data_o,
    output logic [DATA_WIDTH/8-1:0]     way_inp_strb_o,
    output logic                        way_inp_valid_o,
    input  logic                        way_inp_ready_i,
    // data-way read return (no backpressure)
    input  logic [DATA_WIDTH-1:0]       way_out_data_i,
    input  logic                        way_out_valid_i,
    // AXI slave-port R channel
    output logic [ID_WIDTH-1:0]         r_chan_id_o,
    output logic [DATA_WIDTH-1:0]       r_chan_data_o,
    output logic [1:0]                  r_chan_resp_o,
    output logic                        r_chan_last_o,
    output logic                        r_chan_user_o,
    output logic                        r_chan_valid_o,
    input  logic                        r_chan_ready_i,
    // line unlock
    output logic [INDEX_WIDTH-1:0]      r_unlock_index_o,
    output logic [SET_ASSO-1:0]         r_unlock_way_ind_o,
    output logic                        r_unlock_req_o,
    input  logic                        r_unlock_gnt_i
);

    localparam int              c_cnt_w        = $clog2(RBUF_DEPTH + 1);
    localparam int              c_ptr_w        = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(RBUF_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(RBUF_DEPTH - 1);
    localparam logic [1:0]      c_r_chan_unit  = 2'd1;
    localparam logic [1:0]      c_burst_fixed  = 2'b00;
    localparam logic [1:0]      c_resp_slverr  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
        logic                last;
        logic                err;
    } meta_t;

    // descriptor being walked
    state_t                  r_state;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [1:0]              r_resp;
    logic                    r_xlast;
    logic [SET_ASSO-1:0]     r_way_ind;
    logic [INDEX_WIDTH-1:0]  r_index;

    // way requests issued but not yet returned
    logic [c_cnt_w-1:0]      r_outstanding;

    // meta FIFO: one entry per accepted beat
    meta_t                   r_meta_mem [RBUF_DEPTH];
    logic [c_ptr_w-1:0]      r_meta_wr;
    logic [c_ptr_w-1:0]      r_meta_rd;
    logic [c_cnt_w-1:0]      r_meta_cnt;

    // data FIFO: returned way words
    logic [DATA_WIDTH-1:0]   r_data_mem [RBUF_DEPTH];
    logic [c_ptr_w-1:0]      r_data_wr;
    logic [c_ptr_w-1:0]      r_data_rd;
    logic [c_cnt_w-1:0]      r_data_cnt;

    logic                    w_busy;
    logic                    w_err;
    logic                    w_last_beat;
    logic                    w_gnt_ok;
    logic                    w_credit;
    logic                    w_meta_full;
    logic                    w_meta_empty;
    logic                    w_data_full;
    logic                    w_data_empty;
    logic                    w_req_valid;
    logic                    w_req_fire;
    logic                    w_err_fire;
    logic                    w_beat_fire;
    logic                    w_desc_done;
    logic                    w_desc_load;
    logic [ADDR_WIDTH-1:0]   w_num_bytes;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    meta_t                   w_meta_push_val;
    meta_t                   w_meta_head;
    logic                    w_r_fire;
    logic                    w_data_push;
    logic                    w_data_pop;
    logic                    w_unused;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_unused     = test_i;

    assign w_busy       = (r_state == ST_BUSY);
    assign w_err        = (r_resp == c_resp_slverr);
    assign w_last_beat  = (r_len == '0);
    // the final beat of a descriptor is held back until the unlock can be granted
    assign w_gnt_ok     = !w_last_beat || r_unlock_gnt_i;
    assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_data_cnt}) < {1'b0, c_depth};
    assign w_meta_full  = (r_meta_cnt == c_depth);
    assign w_meta_empty = (r_meta_cnt == '0);
    assign w_data_full  = (r_data_cnt == c_depth);
    assign w_data_empty = (r_data_cnt == '0);

    assign w_req_valid  = w_busy && !w_err && w_credit && !w_meta_full && w_gnt_ok;
    assign w_req_fire   = w_req_valid && way_inp_ready_i;
    // error beats skip the data ways and only need meta space
    assign w_err_fire   = w_busy && w_err && !w_meta_full && w_gnt_ok;
    assign w_beat_fire  = w_req_fire || w_err_fire;
    assign w_desc_done  = w_beat_fire && w_last_beat;

    assign desc_ready_o = !w_busy || w_desc_done;
    assign w_desc_load  = desc_valid_i && desc_ready_o;

    assign w_num_bytes  = ADDR_WIDTH'(1) << r_size;
    assign w_addr_next  = (r_addr + w_num_bytes) & ~(w_num_bytes - ADDR_WIDTH'(1));

    // way request payload
    assign way_inp_valid_o      = w_req_valid;
    assign way_inp_cache_unit_o = c_r_chan_unit;
    assign way_inp_way_ind_o    = r_way_ind;
    assign way_inp_line_addr_o  = r_index;
    assign way_inp_blk_offset_o = r_addr[BYTE_OFFSET_LEN +: BLOCK_OFFSET_LEN];
    assign way_inp_we_o         = 1'b0;
    assign way_inp_data_o       = '0;
    assign way_inp_strb_o       = '0;

    // unlock
    assign r_unlock_req_o     = w_desc_done;
    assign r_unlock_index_o   = r_index;
    assign r_unlock_way_ind_o = r_way_ind;

    // meta and R channel
    assign w_meta_push_val.id   = r_id;
    assign w_meta_push_val.resp = r_resp;
    assign w_meta_push_val.last = w_last_beat && r_xlast;
    assign w_meta_push_val.err  = w_err;
    assign w_meta_head          = r_meta_mem[r_meta_rd];

    assign r_chan_valid_o = !w_meta_empty && (w_meta_head.err || !w_data_empty);
    assign r_chan_id_o    = w_meta_head.id;
    assign r_chan_resp_o  = w_meta_head.resp;
    assign r_chan_last_o  = w_meta_head.last;
    assign r_chan_user_o  = 1'b0;
    assign r_chan_data_o  = w_meta_head.err ? '0 : r_data_mem[r_data_rd];

    assign w_r_fire    = r_chan_valid_o && r_chan_ready_i;
    assign w_data_pop  = w_r_fire && !w_meta_head.err;
    assign w_data_push = way_out_valid_i;

    // descriptor walker: latch, count down beats, advance address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_resp    <= '0;
            r_xlast   <= 1'b0;
            r_way_ind <= '0;
            r_index   <= '0;
        end else if (w_desc_load) begin
            r_state   <= ST_BUSY;
            r_id      <= desc_a_x_id_i;
            r_addr    <= desc_a_x_addr_i;
            r_len     <= desc_a_x_len_i;
            r_size    <= desc_a_x_size_i;
            r_burst   <= desc_a_x_burst_i;
            r_resp    <= desc_x_resp_i;
            r_xlast   <= desc_x_last_i;
            r_way_ind <= desc_way_ind_i;
            r_index   <= desc_index_partition_i;
        end else if (w_desc_done) begin
            r_state   <= ST_IDLE;
        end else if (w_beat_fire) begin
            r_len     <= r_len - LEN_WIDTH'(1);
            if (r_burst != c_burst_fixed) begin
                r_addr <= w_addr_next;
            end
        end
    end

    // in-flight way request count; issue and return in one cycle cancel out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_req_fire, way_out_valid_i})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_w'(1);
                2'b01:   r_outstanding <= r_outstanding - c_cnt_w'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // meta FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta_wr  <= '0;
            r_meta_rd  <= '0;
            r_meta_cnt <= '0;
        end else begin
            if (w_beat_fire) r_meta_wr <= ptr_inc(r_meta_wr);
            if (w_r_fire)    r_meta_rd <= ptr_inc(r_meta_rd);
            r_meta_cnt <= r_meta_cnt + c_cnt_w'(w_beat_fire) - c_cnt_w'(w_r_fire);
        end
    end

    // meta FIFO storage
    always_ff @(posedge clk_i) begin
        if (w_beat_fire) r_meta_mem[r_meta_wr] <= w_meta_push_val;
    end

    // data FIFO pointers and occupancy; push and pop together are legal at full
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_wr  <= '0;
            r_data_rd  <= '0;
            r_data_cnt <= '0;
        end else begin
            if (w_data_push) r_data_wr <= ptr_inc(r_data_wr);
            if (w_data_pop)  r_data_rd <= ptr_inc(r_data_rd);
            r_data_cnt <= r_data_cnt + c_cnt_w'(w_data_push) - c_cnt_w'(w_data_pop);
        end
    end

    // data FIFO storage
    always_ff @(posedge clk_i) begin
        if (w_data_push) r_data_mem[r_data_wr] <= way_out_data_i;
    end

`ifndef SYNTHESIS
    // credit accounting guarantees a returned word always has a free slot
    a_no_data_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(w_data_push && w_data_full && !w_data_pop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_read_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_llc_read_unit
//  Brief    : Directed bench for axi_llc_read_unit: a table of descriptors
//             with hand-computed block offsets and beat contents, plus
//             sequences for backpressure, unlock stall, back-to-back
//             descriptors and reset mid-burst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_llc_read_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        test_i = 1'b0;
    logic [3:0]  desc_a_x_id_i;
    logic [31:0] desc_a_x_addr_i;
    logic [7:0]  desc_a_x_len_i;
    logic [2:0]  desc_a_x_size_i;
    logic [1:0]  desc_a_x_burst_i;
    logic [1:0]  desc_x_resp_i;
    logic        desc_x_last_i;
    logic [3:0]  desc_way_ind_i;
    logic [7:0]  desc_index_partition_i;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [1:0]  way_inp_cache_unit_o;
    logic [3:0]  way_inp_way_ind_o;
    logic [7:0]  way_inp_line_addr_o;
    logic [2:0]  way_inp_blk_offset_o;
    logic        way_inp_we_o;
    logic [63:0] way_inp_data_o;
    logic [7:0]  way_inp_strb_o;
    logic        way_inp_valid_o;
    logic        way_inp_ready_i = 1'b1;
    logic [63:0] way_out_data_i;
    logic        way_out_valid_i;
    logic [3:0]  r_chan_id_o;
    logic [63:0] r_chan_data_o;
    logic [1:0]  r_chan_resp_o;
    logic        r_chan_last_o;
    logic        r_chan_user_o;
    logic        r_chan_valid_o;
    logic        r_chan_ready_i;
    logic [7:0]  r_unlock_index_o;
    logic [3:0]  r_unlock_way_ind_o;
    logic        r_unlock_req_o;
    logic        r_unlock_gnt_i;

    always #5 clk = ~clk;

    axi_llc_read_unit #(.RBUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .test_i(test_i),
        .desc_a_x_id_i(desc_a_x_id_i), .desc_a_x_addr_i(desc_a_x_addr_i),
        .desc_a_x_len_i(desc_a_x_len_i), .desc_a_x_size_i(desc_a_x_size_i),
        .desc_a_x_burst_i(desc_a_x_burst_i), .desc_x_resp_i(desc_x_resp_i),
        .desc_x_last_i(desc_x_last_i), .desc_way_ind_i(desc_way_ind_i),
        .desc_index_partition_i(desc_index_partition_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .way_inp_cache_unit_o(way_inp_cache_unit_o), .way_inp_way_ind_o(way_inp_way_ind_o),
        .way_inp_line_addr_o(way_inp_line_addr_o), .way_inp_blk_offset_o(way_inp_blk_offset_o),
        .way_inp_we_o(way_inp_we_o), .way_inp_data_o(way_inp_data_o),
        .way_inp_strb_o(way_inp_strb_o), .way_inp_valid_o(way_inp_valid_o),
        .way_inp_ready_i(way_inp_ready_i),
        .way_out_data_i(way_out_data_i), .way_out_valid_i(way_out_valid_i),
        .r_chan_id_o(r_chan_id_o), .r_chan_data_o(r_chan_data_o),
        .r_chan_resp_o(r_chan_resp_o), .r_chan_last_o(r_chan_last_o),
        .r_chan_user_o(r_chan_user_o), .r_chan_valid_o(r_chan_valid_o),
        .r_chan_ready_i(r_chan_ready_i),
        .r_unlock_index_o(r_unlock_index_o), .r_unlock_way_ind_o(r_unlock_way_ind_o),
        .r_unlock_req_o(r_unlock_req_o), .r_unlock_gnt_i(r_unlock_gnt_i)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic        xlast;
        logic [3:0]  way;
        logic [7:0]  index;
        logic [63:0] base;     // way model returns base + request number
        int          exp_reqs;
        logic [31:0] exp_blk;  // nibble k = expected blk_offset of request k
    } vec_t;

    typedef struct { logic [2:0] blk; logic [7:0] line; logic [3:0] way; logic [1:0] unit; logic we; } req_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } beat_t;
    typedef struct { int due; logic [63:0] data; } ret_t;

    req_t        req_q[$];
    beat_t       r_q[$];
    ret_t        pend_q[$];
    int          unlock_cyc_q[$];
    int          desc_cyc_q[$];
    logic [7:0]  unlock_index;
    logic [3:0]  unlock_way;
    int          cyc = 0;
    int          outst = 0;
    int          max_outst = 0;
    int          last_req_cyc = -1;
    int          req_idx = 0;
    logic [63:0] way_base = '0;

    int errors = 0;
    int checks = 0;

    // Monitor and way-memory model: sample mid-cycle, answer 3 cycles later.
    initial begin
        way_out_valid_i = 1'b0;
        way_out_data_i  = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                pend_q.delete();
                outst = 0;
            end else begin
                if (way_out_valid_i) outst--;
                if (way_inp_valid_o && way_inp_ready_i) begin
                    req_q.push_back('{way_inp_blk_offset_o, way_inp_line_addr_o,
                                      way_inp_way_ind_o, way_inp_cache_unit_o, way_inp_we_o});
                    pend_q.push_back('{cyc + 3, way_base + 64'(req_idx)});
                    req_idx++;
                    outst++;
                    last_req_cyc = cyc;
                end
                if (outst > max_outst) max_outst = outst;
                if (r_chan_valid_o && r_chan_ready_i)
                    r_q.push_back('{r_chan_id_o, r_chan_data_o, r_chan_resp_o, r_chan_last_o});
                if (r_unlock_req_o) begin
                    unlock_cyc_q.push_back(cyc);
                    unlock_index = r_unlock_index_o;
                    unlock_way   = r_unlock_way_ind_o;
                end
                if (desc_valid_i && desc_ready_o) desc_cyc_q.push_back(cyc);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                way_out_valid_i = 1'b1;
                way_out_data_i  = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                way_out_valid_i = 1'b0;
                way_out_data_i  = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_state(input logic [63:0] base);
        req_q.delete();
        r_q.delete();
        unlock_cyc_q.delete();
        desc_cyc_q.delete();
        req_idx   = 0;
        max_outst = 0;
        way_base  = base;
    endtask

    // Present a descriptor and hold it until accepted; returns in drive phase.
    task automatic send_desc(input vec_t v);
        bit ok;
        desc_a_x_id_i          = v.id;
        desc_a_x_addr_i        = v.addr;
        desc_a_x_len_i         = v.len;
        desc_a_x_size_i        = v.size;
        desc_a_x_burst_i       = v.burst;
        desc_x_resp_i          = v.resp;
        desc_x_last_i          = v.xlast;
        desc_way_ind_i         = v.way;
        desc_index_partition_i = v.index;
        desc_valid_i           = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (desc_ready_o) ok = 1'b1;
        end
        tick();
        desc_valid_i = 1'b0;
        if (!ok) check("desc_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_beats(input int n, input string name);
        int i = 0;
        while (r_q.size() < n && i < 400) begin
            @(negedge clk);
            i++;
        end
        repeat (6) tick();
        if (r_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats, expected %0d", name, r_q.size(), n);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                                input logic xlast, input logic [3:0] way, input logic [7:0] index,
                                input logic [63:0] base, input int exp_reqs, input logic [31:0] exp_blk);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.resp = resp;
        v.xlast = xlast; v.way = way; v.index = index; v.base = base;
        v.exp_reqs = exp_reqs; v.exp_blk = exp_blk;
        return v;
    endfunction

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, OKAY = 2'b00, SLVERR = 2'b10;

    vec_t vecs[7];
    vec_t va, vb;
    int   n_at_rst;
    int   reqs_at_rst;

    initial begin
        // id  addr   len size burst resp  xlast way   index  base     reqs blk-offsets
        vecs[0] = mk(4'd3, 32'h00, 8'd0, 3'd3, INCR,  OKAY,   1'b1, 4'b0010, 8'h12, 64'hA5,   1, 32'h0);
        vecs[1] = mk(4'd1, 32'h40, 8'd3, 3'd3, INCR,  OKAY,   1'b1, 4'b0001, 8'h34, 64'h1000, 4, 32'h3210);
        vecs[2] = mk(4'd2, 32'h48, 8'd3, 3'd3, FIXED, OKAY,   1'b1, 4'b0100, 8'h56, 64'h2000, 4, 32'h1111);
        vecs[3] = mk(4'd5, 32'h40, 8'd1, 3'd3, INCR,  SLVERR, 1'b1, 4'b1000, 8'h78, 64'h3000, 0, 32'h0);
        vecs[4] = mk(4'd7, 32'h44, 8'd3, 3'd2, INCR,  OKAY,   1'b1, 4'b0001, 8'h9A, 64'h4000, 4, 32'h2110);
        vecs[5] = mk(4'd4, 32'h43, 8'd1, 3'd3, INCR,  OKAY,   1'b0, 4'b0010, 8'hBC, 64'h5000, 2, 32'h10);
        vecs[6] = mk(4'd9, 32'h78, 8'd1, 3'd3, INCR,  OKAY,   1'b1, 4'b0100, 8'hDE, 64'h6000, 2, 32'h07);

        rst_i = 1'b1;
        desc_valid_i = 1'b0;
        desc_a_x_id_i = '0; desc_a_x_addr_i = '0; desc_a_x_len_i = '0; desc_a_x_size_i = '0;
        desc_a_x_burst_i = '0; desc_x_resp_i = '0; desc_x_last_i = 1'b0;
        desc_way_ind_i = '0; desc_index_partition_i = '0;
        r_chan_ready_i = 1'b1;
        r_unlock_gnt_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("reset_desc_ready", 64'(desc_ready_o), 64'd1);
        check("reset_way_valid", 64'(way_inp_valid_o), 64'd0);
        check("reset_r_valid", 64'(r_chan_valid_o), 64'd0);
        check("reset_unlock_req", 64'(r_unlock_req_o), 64'd0);

        // ---------------- table-driven descriptors ----------------
        for (int t = 0; t < 7; t++) begin
            vec_t v;
            v = vecs[t];
            clear_state(v.base);
            send_desc(v);
            wait_beats(int'(v.len) + 1, $sformatf("v%0d", t));
            check($sformatf("v%0d_req_count", t), 64'(req_q.size()), 64'(v.exp_reqs));
            for (int k = 0; k < req_q.size() && k < v.exp_reqs; k++) begin
                check($sformatf("v%0d_req%0d_blk", t, k), 64'(req_q[k].blk), 64'(v.exp_blk[k*4 +: 3]));
                check($sformatf("v%0d_req%0d_line", t, k), 64'(req_q[k].line), 64'(v.index));
                check($sformatf("v%0d_req%0d_way", t, k), 64'(req_q[k].way), 64'(v.way));
                check($sformatf("v%0d_req%0d_unit_we", t, k), {61'd0, req_q[k].unit, req_q[k].we}, 64'b010);
            end
            check($sformatf("v%0d_beat_count", t), 64'(r_q.size()), 64'(int'(v.len) + 1));
            for (int k = 0; k < r_q.size() && k <= int'(v.len); k++) begin
                check($sformatf("v%0d_beat%0d_id", t, k), 64'(r_q[k].id), 64'(v.id));
                check($sformatf("v%0d_beat%0d_resp", t, k), 64'(r_q[k].resp), 64'(v.resp));
                check($sformatf("v%0d_beat%0d_data", t, k), r_q[k].data,
                      (v.resp == SLVERR) ? 64'd0 : v.base + 64'(k));
                check($sformatf("v%0d_beat%0d_last", t, k), 64'(r_q[k].last),
                      (k == int'(v.len)) ? 64'(v.xlast) : 64'd0);
            end
            check($sformatf("v%0d_unlock_count", t), 64'(unlock_cyc_q.size()), 64'd1);
            check($sformatf("v%0d_unlock_index", t), 64'(unlock_index), 64'(v.index));
            check($sformatf("v%0d_unlock_way", t), 64'(unlock_way), 64'(v.way));
            if (v.resp != SLVERR && unlock_cyc_q.size() > 0)
                check($sformatf("v%0d_unlock_cycle", t), 64'(unlock_cyc_q[0]), 64'(last_req_cyc));
        end

        // ---------------- R backpressure during len=7 ----------------
        clear_state(64'h7000);
        r_chan_ready_i = 1'b0;
        send_desc(mk(4'd6, 32'h0, 8'd7, 3'd3, INCR, OKAY, 1'b1, 4'b0001, 8'h11, 64'h7000, 8, 32'h76543210));
        repeat (20) tick();
        check("bp_reqs_while_stalled", 64'(req_q.size()), 64'(DEPTH));
        check("bp_beats_while_stalled", 64'(r_q.size()), 64'd0);
        r_chan_ready_i = 1'b1;
        wait_beats(8, "bp");
        check("bp_req_count", 64'(req_q.size()), 64'd8);
        check("bp_max_outstanding_ok", 64'(max_outst <= DEPTH), 64'd1);
        check("bp_beat_count", 64'(r_q.size()), 64'd8);
        for (int k = 0; k < r_q.size() && k < 8; k++) begin
            check($sformatf("bp_beat%0d_data", k), r_q[k].data, 64'h7000 + 64'(k));
            check($sformatf("bp_beat%0d_last", k), 64'(r_q[k].last), (k == 7) ? 64'd1 : 64'd0);
        end

        // ---------------- unlock stall on the final beat ----------------
        clear_state(64'h8000);
        r_unlock_gnt_i = 1'b0;
        send_desc(mk(4'd2, 32'h0, 8'd2, 3'd3, INCR, OKAY, 1'b1, 4'b0100, 8'h22, 64'h8000, 3, 32'h210));
        repeat (10) tick();
        check("stall_reqs_held", 64'(req_q.size()), 64'd2);
        check("stall_no_unlock", 64'(unlock_cyc_q.size()), 64'd0);
        check("stall_desc_ready", 64'(desc_ready_o), 64'd0);
        check("stall_way_valid", 64'(way_inp_valid_o), 64'd0);
        r_unlock_gnt_i = 1'b1;
        @(negedge clk);
        check("stall_release_req_and_unlock", {62'd0, way_inp_valid_o, r_unlock_req_o}, 64'b11);
        tick();
        wait_beats(3, "stall");
        check("stall_req_count", 64'(req_q.size()), 64'd3);
        check("stall_unlock_count", 64'(unlock_cyc_q.size()), 64'd1);
        if (unlock_cyc_q.size() > 0)
            check("stall_unlock_cycle", 64'(unlock_cyc_q[0]), 64'(last_req_cyc));

        // ---------------- back-to-back descriptors merged into one burst ----------------
        clear_state(64'h9000);
        va = mk(4'd6, 32'h00, 8'd1, 3'd3, INCR, OKAY, 1'b0, 4'b0001, 8'h33, 64'h9000, 2, 32'h10);
        vb = mk(4'd6, 32'h10, 8'd1, 3'd3, INCR, OKAY, 1'b1, 4'b0001, 8'h33, 64'h9000, 2, 32'h32);
        send_desc(va);
        send_desc(vb);
        wait_beats(4, "b2b");
        check("b2b_beat_count", 64'(r_q.size()), 64'd4);
        for (int k = 0; k < r_q.size() && k < 4; k++) begin
            check($sformatf("b2b_beat%0d_data", k), r_q[k].data, 64'h9000 + 64'(k));
            check($sformatf("b2b_beat%0d_last", k), 64'(r_q[k].last), (k == 3) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < req_q.size() && k < 4; k++)
            check($sformatf("b2b_req%0d_blk", k), 64'(req_q[k].blk), 64'(k));
        check("b2b_unlock_count", 64'(unlock_cyc_q.size()), 64'd2);
        if (unlock_cyc_q.size() > 0 && desc_cyc_q.size() > 1)
            check("b2b_second_desc_same_cycle", 64'(desc_cyc_q[1]), 64'(unlock_cyc_q[0]));

        // ---------------- reset mid-burst ----------------
        clear_state(64'hA000);
        send_desc(mk(4'd1, 32'h0, 8'd7, 3'd3, INCR, OKAY, 1'b1, 4'b0010, 8'h44, 64'hA000, 8, 32'h0));
        begin
            int i = 0;
            while (r_q.size() < 2 && i < 200) begin
                @(negedge clk);
                i++;
            end
            tick();
        end
        rst_i = 1'b1;
        #1;
        n_at_rst    = r_q.size();
        reqs_at_rst = req_q.size();
        check("rst_way_valid", 64'(way_inp_valid_o), 64'd0);
        check("rst_r_valid", 64'(r_chan_valid_o), 64'd0);
        check("rst_unlock_req", 64'(r_unlock_req_o), 64'd0);
        check("rst_desc_ready", 64'(desc_ready_o), 64'd1);
        check("rst_burst_truncated", 64'(n_at_rst >= 2 && n_at_rst < 8), 64'd1);
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (30) tick();
        check("rst_no_more_beats", 64'(r_q.size()), 64'(n_at_rst));
        check("rst_no_more_reqs", 64'(req_q.size()), 64'(reqs_at_rst));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
